// File: rtl/io_cmd_pkg.sv
// Shared definitions for the IO command arbiter: opcodes, FSM states and
// the opcode classification helper.
package io_cmd_pkg;

  localparam logic [7:0] RST      = 8'h01;
  localparam logic [7:0] ON       = 8'h05;
  localparam logic [7:0] OFF      = 8'h06;
  localparam logic [7:0] GPIOOUT  = 8'h07;
  localparam logic [7:0] GPIOIN   = 8'h08;
  localparam logic [7:0] UARTSEND = 8'h09;
  localparam logic [7:0] UARTSEL  = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  // Only GPIO reads return data; unknown opcodes behave as posted.
  function automatic logic is_responding(input logic [7:0] opcode);
    logic r;
    case (opcode)
      RST, ON, OFF, GPIOOUT, UARTSEND, UARTSEL: r = 1'b0;
      GPIOIN:                                   r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr+1 (mod NREQ).
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IW'((32'(ptr) + off) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/io_cmd_arbiter.sv
// Round-robin arbiter sharing the IO command port between NREQ requesters.
// Optional IO_ARB_RST_GUARD_EN: only requester 0 may issue the RST opcode.
module io_cmd_arbiter
  import io_cmd_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CMD_W   = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*CMD_W-1:0]     req_cmd,
  output logic [NREQ-1:0]           req_ack,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [CMD_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      io_start,
  output logic [CMD_W-1:0]          io_in,
  input  logic                      io_rdy,
  input  logic [CMD_W-1:0]          io_out,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_e       state;
  logic [IW-1:0]    ptr;
  logic [7:0]       op_q;
  logic             guard_q;
  logic [CW-1:0]    cnt;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [CMD_W-1:0] pick_cmd;
  logic             pick_guarded;

  logic             done;
  logic [CMD_W-1:0] done_data;
  logic             done_err;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_cmd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_cmd = req_cmd[i*CMD_W +: CMD_W];
    end
  end

`ifdef IO_ARB_RST_GUARD_EN
  assign pick_guarded = (pick_cmd[CMD_W-1 -: 8] == RST) && (pick_idx != '0);
`else
  assign pick_guarded = 1'b0;
`endif

  // Ack is a same-cycle grant indication, suppressed while reset is held.
  assign req_ack = (rst && state == IDLE && pick_found) ? (NREQ'(1) << pick_idx) : '0;

  always_comb begin
    done      = 1'b0;
    done_data = '0;
    done_err  = 1'b0;
    case (state)
      ISSUE: begin
        if (guard_q) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (!is_responding(op_q)) begin
          done = 1'b1;
        end else if (io_rdy) begin
          done      = 1'b1;
          done_data = io_out;
        end
      end
      WAIT: begin
        if (io_rdy) begin
          done      = 1'b1;
          done_data = io_out;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered on entry to the state they belong to, so
  // io_start is high during ISSUE and rsp_valid during RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      op_q      <= '0;
      guard_q   <= 1'b0;
      cnt       <= '0;
      grant_id  <= '0;
      io_start  <= 1'b0;
      io_in     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      io_start  <= 1'b0;
      io_in     <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            op_q     <= pick_cmd[CMD_W-1 -: 8];
            guard_q  <= pick_guarded;
            grant_id <= pick_idx;
            ptr      <= pick_idx;
            io_start <= !pick_guarded;
            io_in    <= pick_guarded ? '0 : pick_cmd;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (done) begin
            rsp_valid <= NREQ'(1) << grant_id;
            rsp_data  <= done_data;
            rsp_err   <= done_err;
            state     <= RESP;
          end else if (state == ISSUE) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_data <= '0;
          rsp_err  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_cmd_arbiter.sv
// Directed bench for io_cmd_arbiter (NREQ=4, TIMEOUT=4); RST-guard
// expectations follow IO_ARB_RST_GUARD_EN.
module tb_io_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [95:0] req_cmd = '0;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_valid;
  logic [23:0] rsp_data;
  logic        rsp_err;
  logic        io_start;
  logic [23:0] io_in;
  logic        io_rdy = 1'b0;
  logic [23:0] io_out = '0;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  io_cmd_arbiter #(
    .NREQ    (4),
    .CMD_W   (24),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .io_start  (io_start),
    .io_in     (io_in),
    .io_rdy    (io_rdy),
    .io_out    (io_out),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [23:0] c);
    req_cmd[i*24 +: 24] = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rspd"}, 32'(rsp_data), 32'h0);
    chk({tag, "_rspe"}, 32'(rsp_err), 32'h0);
    chk({tag, "_start"}, 32'(io_start), 32'h0);
    chk({tag, "_ioin"}, 32'(io_in), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_gid"}, 32'(grant_id), 32'h0);
  endtask

  logic [23:0] cmd4 [4];
  logic [3:0]  exp_ack;

  initial begin
    // Reset: outputs zero, ack suppressed even with requests pending.
    req_valid = 4'hF;
    step(); step();
    @(negedge clk);
    chk_all_zero("rst");
    step();
    req_valid = '0;
    rst = 1'b1;

    // 1: posted ON from req0.
    set_cmd(0, 24'h050002);
    step(); req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ack", 32'(req_ack), 32'h1);
    chk("t1_start_T", 32'(io_start), 32'h0);
    chk("t1_busy_T", 32'(busy), 32'h0);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t1_start", 32'(io_start), 32'h1);
    chk("t1_ioin", 32'(io_in), 32'h050002);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_gid", 32'(grant_id), 32'h0);
    chk("t1_rspv_T1", 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t1_rspv", 32'(rsp_valid), 32'h1);
    chk("t1_rspd", 32'(rsp_data), 32'h0);
    chk("t1_rspe", 32'(rsp_err), 32'h0);
    chk("t1_start_off", 32'(io_start), 32'h0);
    chk("t1_ioin_off", 32'(io_in), 32'h0);
    step();
    @(negedge clk);
    chk("t1_idle_rspv", 32'(rsp_valid), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // 2: GPIOIN from req1, io_rdy three cycles after io_start.
    set_cmd(1, 24'h080000);
    step(); req_valid = 4'b0010;
    @(negedge clk);
    chk("t2_ack", 32'(req_ack), 32'h2);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t2_start", 32'(io_start), 32'h1);
    chk("t2_ioin", 32'(io_in), 32'h080000);
    step(); step();
    step(); io_rdy = 1'b1; io_out = 24'h00A5C3;
    @(negedge clk);
    chk("t2_rspv_T4", 32'(rsp_valid), 32'h0);
    chk("t2_busy_T4", 32'(busy), 32'h1);
    step(); io_rdy = 1'b0; io_out = '0;
    @(negedge clk);
    chk("t2_rspv", 32'(rsp_valid), 32'h2);
    chk("t2_rspd", 32'(rsp_data), 32'h00A5C3);
    chk("t2_rspe", 32'(rsp_err), 32'h0);
    step();
    @(negedge clk);
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // 3: GPIOIN from req2, io_rdy never comes -> timeout at T+6.
    set_cmd(2, 24'h080000);
    step(); req_valid = 4'b0100;
    @(negedge clk);
    chk("t3_ack", 32'(req_ack), 32'h4);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t3_start", 32'(io_start), 32'h1);
    for (int c = 2; c <= 5; c++) begin
      step();
      @(negedge clk);
      chk("t3_wait_rspv", 32'(rsp_valid), 32'h0);
    end
    step();
    @(negedge clk);
    chk("t3_rspv", 32'(rsp_valid), 32'h4);
    chk("t3_rspd", 32'(rsp_data), 32'h0);
    chk("t3_rspe", 32'(rsp_err), 32'h1);
    chk("t3_busy_resp", 32'(busy), 32'h1);
    step();
    @(negedge clk);
    chk("t3_idle_busy", 32'(busy), 32'h0);

    // 3b: io_rdy on the timeout cycle wins; io_rdy during RESP is ignored.
    set_cmd(3, 24'h080000);
    step(); req_valid = 4'b1000;
    @(negedge clk);
    chk("t3b_ack", 32'(req_ack), 32'h8);
    step(); req_valid = '0;
    step(); step(); step();
    step(); io_rdy = 1'b1; io_out = 24'h123456;
    step(); io_out = 24'hBADBAD;
    @(negedge clk);
    chk("t3b_rspv", 32'(rsp_valid), 32'h8);
    chk("t3b_rspd", 32'(rsp_data), 32'h123456);
    chk("t3b_rspe", 32'(rsp_err), 32'h0);
    step();
    @(negedge clk);
    chk("t3b_after_rspd", 32'(rsp_data), 32'h0);
    chk("t3b_after_rspv", 32'(rsp_valid), 32'h0);
    chk("t3b_after_busy", 32'(busy), 32'h0);
    io_rdy = 1'b0; io_out = '0;

    // 4: all requesters pending, posted commands -> 0,1,2,3,0 every 3 cycles.
    cmd4[0] = 24'h070010; cmd4[1] = 24'h070021;
    cmd4[2] = 24'h0A0032; cmd4[3] = 24'h090043;
    for (int i = 0; i < 4; i++) set_cmd(i, cmd4[i]);
    step(); req_valid = 4'hF;
    for (int c = 0; c < 13; c++) begin
      if (c != 0) step();
      @(negedge clk);
      exp_ack = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      chk("t4_ack", 32'(req_ack), 32'(exp_ack));
      if (c % 3 == 1) chk("t4_ioin", 32'(io_in), 32'(cmd4[(c / 3) % 4]));
    end
    step(); req_valid = '0;
    step();
    @(negedge clk);
    chk("t4_last_rspv", 32'(rsp_valid), 32'h1);
    step();

    // 5: reset while in WAIT, then req2 gets first grant with no stale response.
    set_cmd(1, 24'h080000);
    step(); req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_ack", 32'(req_ack), 32'h2);
    step(); req_valid = '0;
    step();
    @(negedge clk);
    chk("t5_wait_busy", 32'(busy), 32'h1);
    #1;
    rst = 1'b0;
    req_valid = 4'b0100;
    set_cmd(2, 24'h090041);
    io_rdy = 1'b1; io_out = 24'hFFFFFF;
    #1;
    chk_all_zero("t5_rst");
    step(); step();
    @(negedge clk);
    chk_all_zero("t5_rst_hold");
    step(); rst = 1'b1; io_rdy = 1'b0; io_out = '0;
    @(negedge clk);
    chk("t5_ack2", 32'(req_ack), 32'h4);
    chk("t5_rspv_idle", 32'(rsp_valid), 32'h0);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t5_start", 32'(io_start), 32'h1);
    chk("t5_ioin", 32'(io_in), 32'h090041);
    chk("t5_gid", 32'(grant_id), 32'h2);
    chk("t5_rspv_issue", 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t5_rspv", 32'(rsp_valid), 32'h4);
    chk("t5_rspe", 32'(rsp_err), 32'h0);
    step();
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 32'h0);

    // 6: RST opcode from req1 (guarded or forwarded), then from req0.
    set_cmd(1, 24'h010000);
    step(); req_valid = 4'b0010;
    @(negedge clk);
    chk("t6_ack1", 32'(req_ack), 32'h2);
    step(); req_valid = '0;
    @(negedge clk);
`ifdef IO_ARB_RST_GUARD_EN
    chk("t6_start1", 32'(io_start), 32'h0);
    chk("t6_ioin1", 32'(io_in), 32'h0);
`else
    chk("t6_start1", 32'(io_start), 32'h1);
    chk("t6_ioin1", 32'(io_in), 32'h010000);
`endif
    step();
    @(negedge clk);
    chk("t6_rspv1", 32'(rsp_valid), 32'h2);
    chk("t6_rspd1", 32'(rsp_data), 32'h0);
`ifdef IO_ARB_RST_GUARD_EN
    chk("t6_rspe1", 32'(rsp_err), 32'h1);
`else
    chk("t6_rspe1", 32'(rsp_err), 32'h0);
`endif
    set_cmd(0, 24'h010000);
    step(); req_valid = 4'b0001;
    @(negedge clk);
    chk("t6_ack0", 32'(req_ack), 32'h1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t6_start0", 32'(io_start), 32'h1);
    chk("t6_ioin0", 32'(io_in), 32'h010000);
    step();
    @(negedge clk);
    chk("t6_rspv0", 32'(rsp_valid), 32'h1);
    chk("t6_rspe0", 32'(rsp_err), 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
